// File: rtl/stage_fetch_if.sv
// rtl/stage_fetch_if.sv - fetch stage bundle: redirect/stall controls, instruction ROM port, F/D latch and counters
interface stage_fetch_if;
  logic        stall;
  logic        take_branch;
  logic [31:0] pc_in;
  logic [11:0] imem_addr;
  logic [31:0] imem_q;
  logic [31:0] pc_out;
  logic [31:0] fd_insn;
  logic [31:0] fd_pc_plus_4;
  logic        fd_valid;
  logic        flush_dx;
  logic [31:0] fetch_count;
  logic [15:0] bubble_count;

  modport master (
    input  stall, take_branch, pc_in, imem_q,
    output imem_addr, pc_out, fd_insn, fd_pc_plus_4, fd_valid,
           flush_dx, fetch_count, bubble_count
  );

  modport slave (
    output stall, take_branch, pc_in, imem_q,
    input  imem_addr, pc_out, fd_insn, fd_pc_plus_4, fd_valid,
           flush_dx, fetch_count, bubble_count
  );
endinterface

// File: rtl/stage_fetch.sv
// rtl/stage_fetch.sv - instruction fetch stage with PC, synchronous ROM addressing and the F/D latch
module stage_fetch (
  input  logic          clock,
  input  logic          reset,
  stage_fetch_if.master bus
);
  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] SQUASH = 2'd2;

  logic [31:0] pc;
  logic [31:0] fetch_pc;
  logic [1:0]  state;
  logic [31:0] fd_insn;
  logic [31:0] fd_pc_plus_4;
  logic        fd_valid;
  logic [31:0] fetch_count;
  logic [15:0] bubble_count;
  logic        replay;
  logic [15:0] bubble_next;

  // While stalled in RUN, re-read fetch_pc so imem_q still holds its word on release.
  assign replay        = (state == RUN) && bus.stall && !bus.take_branch;
  assign bus.imem_addr = replay ? fetch_pc[11:0] : pc[11:0];
  assign bus.flush_dx  = bus.take_branch;

  assign bus.pc_out       = pc;
  assign bus.fd_insn      = fd_insn;
  assign bus.fd_pc_plus_4 = fd_pc_plus_4;
  assign bus.fd_valid     = fd_valid;
  assign bus.fetch_count  = fetch_count;
  assign bus.bubble_count = bubble_count;

  assign bubble_next = (bubble_count == 16'hFFFF) ? bubble_count : bubble_count + 16'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc           <= 32'd0;
      fetch_pc     <= 32'd0;
      state        <= FILL;
      fd_insn      <= 32'd0;
      fd_pc_plus_4 <= 32'd0;
      fd_valid     <= 1'b0;
      fetch_count  <= 32'd0;
      bubble_count <= 16'd0;
    end else if (bus.take_branch) begin
      pc           <= bus.pc_in;
      fetch_pc     <= pc;
      state        <= SQUASH;
      fd_insn      <= 32'd0;
      fd_pc_plus_4 <= 32'd0;
      fd_valid     <= 1'b0;
      bubble_count <= bubble_next;
    end else if (!bus.stall) begin
      fetch_pc <= pc;
      pc       <= pc + 32'd1;
      state    <= RUN;
      if (state == RUN) begin
        fd_insn      <= bus.imem_q;
        fd_pc_plus_4 <= fetch_pc + 32'd1;
        fd_valid     <= 1'b1;
        fetch_count  <= fetch_count + 32'd1;
      end else begin
        // FILL/SQUASH: imem_q does not yet hold a word from the current stream.
        fd_insn      <= 32'd0;
        fd_pc_plus_4 <= 32'd0;
        fd_valid     <= 1'b0;
        bubble_count <= bubble_next;
      end
    end
  end
endmodule

// File: tb/tb_stage_fetch.sv
// tb/tb_stage_fetch.sv - directed self-checking bench for stage_fetch
module tb_stage_fetch;
  logic clock;
  logic reset;
  int   vectors;
  int   errors;

  stage_fetch_if bus ();

  stage_fetch dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous ROM: word k holds 32'h100 + k.
  always @(posedge clock) bus.imem_q <= 32'h100 + {20'd0, bus.imem_addr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_fd(input string tag, input logic [31:0] insn, input logic [31:0] p4, input logic v);
    chk({tag, ".insn"}, bus.fd_insn, insn);
    chk({tag, ".pc4"}, bus.fd_pc_plus_4, p4);
    chk({tag, ".valid"}, {31'd0, bus.fd_valid}, {31'd0, v});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".pc"}, bus.pc_out, 32'd0);
    chk_fd(tag, 32'd0, 32'd0, 1'b0);
    chk({tag, ".fc"}, bus.fetch_count, 32'd0);
    chk({tag, ".bc"}, {16'd0, bus.bubble_count}, 32'd0);
    chk({tag, ".addr"}, {20'd0, bus.imem_addr}, 32'd0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    chk_reset_state(tag);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    reset   = 1'b1;
    bus.stall       = 1'b0;
    bus.take_branch = 1'b0;
    bus.pc_in       = 32'd0;
    bus.imem_q      = 32'd0;

    #2;
    bus.take_branch = 1'b1;
    #1;
    chk("rst_flush_hi", {31'd0, bus.flush_dx}, 32'd1);
    chk_reset_state("rst");
    bus.take_branch = 1'b0;
    #1;
    chk("rst_flush_lo", {31'd0, bus.flush_dx}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Fill then free run
    tick();
    chk_fd("fill_e1", 32'd0, 32'd0, 1'b0);
    chk("fill_e1_bc", {16'd0, bus.bubble_count}, 32'd1);
    chk("fill_e1_pc", bus.pc_out, 32'd1);
    for (int k = 2; k <= 11; k++) begin
      tick();
      chk_fd("run", 32'h100 + k - 2, k - 1, 1'b1);
      chk("run_pc", bus.pc_out, k);
    end
    chk("run_fc", bus.fetch_count, 32'd10);
    chk("run_bc", {16'd0, bus.bubble_count}, 32'd1);

    // Redirect to 0x40 while pc_out = 6
    pulse_reset("rst_b");
    repeat (6) tick();
    chk("br_pre_pc", bus.pc_out, 32'd6);
    chk("br_pre_insn", bus.fd_insn, 32'h104);
    bus.take_branch = 1'b1;
    bus.pc_in       = 32'h40;
    #1;
    chk("br_flush", {31'd0, bus.flush_dx}, 32'd1);
    chk("br_addr", {20'd0, bus.imem_addr}, 32'd6);
    chk("br_nocomb_pc", bus.pc_out, 32'd6);
    tick();
    chk_fd("br_b1", 32'd0, 32'd0, 1'b0);
    chk("br_b1_pc", bus.pc_out, 32'h40);
    chk("br_b1_bc", {16'd0, bus.bubble_count}, 32'd2);
    bus.take_branch = 1'b0;
    #1;
    chk("br_flush_lo", {31'd0, bus.flush_dx}, 32'd0);
    tick();
    chk_fd("br_b2", 32'd0, 32'd0, 1'b0);
    chk("br_b2_pc", bus.pc_out, 32'h41);
    tick();
    chk_fd("br_tgt", 32'h140, 32'h41, 1'b1);
    chk("br_fc", bus.fetch_count, 32'd6);
    chk("br_bc", {16'd0, bus.bubble_count}, 32'd3);

    // Three-cycle stall holding 0x105
    pulse_reset("rst_c");
    repeat (7) tick();
    chk("st_pre_insn", bus.fd_insn, 32'h105);
    bus.stall = 1'b1;
    #1;
    chk("st_addr", {20'd0, bus.imem_addr}, 32'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_insn", bus.fd_insn, 32'h105);
      chk("st_pc", bus.pc_out, 32'd7);
    end
    chk("st_fc", bus.fetch_count, 32'd6);
    chk("st_bc", {16'd0, bus.bubble_count}, 32'd1);
    bus.stall = 1'b0;
    tick();
    chk_fd("st_rel1", 32'h106, 32'd7, 1'b1);
    chk("st_rel1_pc", bus.pc_out, 32'd8);
    tick();
    chk_fd("st_rel2", 32'h107, 32'd8, 1'b1);
    chk("st_rel2_fc", bus.fetch_count, 32'd8);

    // Branch beats stall; stall inside SQUASH
    bus.stall       = 1'b1;
    bus.take_branch = 1'b1;
    bus.pc_in       = 32'h20;
    #1;
    chk("bs_flush", {31'd0, bus.flush_dx}, 32'd1);
    chk("bs_addr", {20'd0, bus.imem_addr}, 32'd9);
    tick();
    chk("bs_pc", bus.pc_out, 32'h20);
    chk_fd("bs_bub", 32'd0, 32'd0, 1'b0);
    chk("bs_bc", {16'd0, bus.bubble_count}, 32'd2);
    bus.take_branch = 1'b0;
    #1;
    chk("sq_st_addr", {20'd0, bus.imem_addr}, 32'h20);
    tick();
    chk("sq_st_pc", bus.pc_out, 32'h20);
    chk("sq_st_bc", {16'd0, bus.bubble_count}, 32'd2);
    bus.stall = 1'b0;
    tick();
    chk_fd("sq_bub", 32'd0, 32'd0, 1'b0);
    chk("sq_bub_bc", {16'd0, bus.bubble_count}, 32'd3);
    chk("sq_bub_pc", bus.pc_out, 32'h21);
    tick();
    chk_fd("sq_tgt", 32'h120, 32'h21, 1'b1);
    chk("sq_fc", bus.fetch_count, 32'd9);

    // Async reset in SQUASH, then refill from word 0
    bus.take_branch = 1'b1;
    bus.pc_in       = 32'h80;
    tick();
    bus.take_branch = 1'b0;
    #1;
    pulse_reset("rst_sq");
    tick();
    chk_fd("rf_e1", 32'd0, 32'd0, 1'b0);
    chk("rf_e1_pc", bus.pc_out, 32'd1);
    tick();
    chk_fd("rf_e2", 32'h100, 32'd1, 1'b1);

    // Bubble counter saturation
    bus.take_branch = 1'b1;
    bus.pc_in       = 32'd0;
    repeat (65534) tick();
    chk("sat_reach", {16'd0, bus.bubble_count}, 32'h0000FFFF);
    tick();
    chk("sat_hold", {16'd0, bus.bubble_count}, 32'h0000FFFF);
    chk("sat_fc", bus.fetch_count, 32'd1);
    bus.take_branch = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/stage_fetch.md
STAGE_FETCH -- requirements
Module: stage_fetch

Interface
REQ-001 SHALL: clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high; clears all state immediately, independent of clock.
REQ-003 SHALL: stall  input  1  hazard-unit hold request; freezes PC and the F/D latch.
REQ-004 SHALL: take_branch  input  1  execute-stage redirect (taken bne/blt/bex, j, jal, jr).
REQ-005 SHALL: pc_in  input  32  execute-stage redirect target.
REQ-006 SHALL: imem_addr  output  12  word address to synchronous instruction ROM; data returns on imem_q one cycle later.
REQ-007 SHALL: imem_q  input  32  ROM read data.
REQ-008 SHALL: pc_out  output  32  current PC register, also supplies pc_upper_5 = pc_out[31:27] to execute.
REQ-009 SHALL: fd_insn  output  32  F/D latch instruction; 32'd0 (nop) when bubble.
REQ-010 SHALL: fd_pc_plus_4  output  32  F/D latch next-sequential PC (word-addressed, value = fetched PC + 1).
REQ-011 SHALL: fd_valid  output  1  F/D latch holds a real instruction.
REQ-012 SHALL: flush_dx  output  1  combinational squash of the D->X latch load.
REQ-013 SHALL: fetch_count  output  32  count of valid instructions loaded into F/D, wraps.
REQ-014 SHALL: bubble_count  output  16  count of bubbles loaded into F/D, saturates at 16'hFFFF.

Function
REQ-015 SHALL: internal registers: pc (32), fetch_pc (32, address whose word is on imem_q), state in {FILL, RUN, SQUASH}.
REQ-016 SHALL: imem_addr = fetch_pc[11:0] when state==RUN, stall=1, take_branch=0; otherwise pc[11:0].
REQ-017 SHALL: priority per edge: take_branch > stall > normal advance.
REQ-018 SHALL: normal advance: fetch_pc<=pc; pc<=pc+1 (mod 2^32); F/D<={imem_q, fetch_pc+1, valid=1} in RUN, or bubble {0, 0, 0} in FILL/SQUASH.
REQ-019 SHALL: FILL -> RUN after one advance edge; SQUASH -> RUN after one advance edge.
REQ-020 SHALL: take_branch=1: pc<=pc_in; fetch_pc<=pc; F/D<=bubble; state<=SQUASH, in any state including while stall=1.
REQ-021 SHALL: flush_dx = take_branch, same cycle, combinational.
REQ-022 SHALL: stall=1 with take_branch=0: pc, fetch_pc, F/D, state, counters all hold; the replayed address makes imem_q valid for fetch_pc on release.
REQ-023 SHALL: stall during FILL or SQUASH holds state; the bubble is still issued on the first non-stalled edge.
REQ-024 SHALL: redirect latency: first valid F/D entry from target appears on the 2nd edge after the take_branch edge (two bubbles total).
REQ-025 SHALL: fetch_count increments on each edge loading fd_valid=1; bubble_count increments on each edge loading a bubble; neither changes on stall-hold edges.
REQ-026 SHALL: no combinational path from take_branch or pc_in to fd_* or pc_out; only to flush_dx and imem_addr.

Reset
REQ-027 SHALL: on reset: pc=0, fetch_pc=0, state=FILL, fd_insn=0, fd_pc_plus_4=0, fd_valid=0, fetch_count=0, bubble_count=0; flush_dx follows take_branch.
REQ-028 SHALL: reset asserted mid-SQUASH or mid-stall aborts immediately; first valid F/D after release is ROM word 0 on the 2nd edge.

Verification
REQ-029 SHALL: reset, ROM word k = 32'h100+k -> edge1 bubble (bubble_count=1); edge2 fd_insn=0x100, fd_pc_plus_4=1, fd_valid=1.
REQ-030 SHALL: free run 10 edges after fill -> fd_insn 0x100..0x109 consecutive, fetch_count=10, no gaps.
REQ-031 SHALL: take_branch=1, pc_in=0x40 while pc_out=6 -> flush_dx=1 that cycle; next two F/D loads bubbles; following load fd_insn=0x140, fd_pc_plus_4=0x41; bubble_count +2.
REQ-032 SHALL: stall=1 for 3 cycles with fd_insn=0x105 -> fd_insn, pc_out frozen; after release fd_insn=0x106 then 0x107, no duplicate/skip.
REQ-033 SHALL: take_branch and stall both high, pc_in=0x20 -> redirect taken, pc_out=0x20 next cycle, F/D bubble.
REQ-034 SHALL: reset pulse between clock edges during SQUASH -> all outputs at reset values before next edge; force bubble_count to 0xFFFF then bubble -> stays 0xFFFF.
